// File: rtl/atm_pkg.sv
// Shared definitions for the ATM card/PIN authentication and transaction blocks:
// default widths, FSM state encoding and the constant account / default-PIN tables.
package atm_pkg;

  localparam int ACCT_W_DEF = 17;
  localparam int PIN_W_DEF  = 17;
  localparam int MAX_ACCTS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_WAIT_PIN = 3'd2,
    ST_CHECK    = 3'd3,
    ST_AUTH     = 3'd4,
    ST_LOCKED   = 3'd5,
    ST_EJECT    = 3'd6
  } state_t;

  localparam logic [ACCT_W_DEF-1:0] ACCT_NO [MAX_ACCTS] = '{
    17'h0A5C0, 17'h0A6F7, 17'h0A82E, 17'h0A965,
    17'h0AA9C, 17'h0ABD3, 17'h0AD0A, 17'h0AE41,
    17'h0AF78, 17'h0B0AF, 17'h0B1E6, 17'h0B31D,
    17'h0B454, 17'h0B58B, 17'h0B6C2, 17'h0B7F9
  };

  localparam logic [PIN_W_DEF-1:0] DEFAULT_PIN [MAX_ACCTS] = '{
    17'h04D20, 17'h05E31, 17'h06F42, 17'h08053,
    17'h09164, 17'h0A275, 17'h0B386, 17'h0C497,
    17'h0D5A8, 17'h0E6B9, 17'h0F7CA, 17'h108DB,
    17'h119EC, 17'h12AFD, 17'h13C0E, 17'h14D1F
  };

endpackage

// File: rtl/atm_pin_auth_if.sv
// Card-reader / keypad / ATM-side signals of the PIN authentication stage.
interface atm_pin_auth_if #(
  parameter int ACCT_W = 17,
  parameter int PIN_W  = 17
);
  logic              card_in;
  logic [ACCT_W-1:0] acct_no;
  logic              pin_valid;
  logic [PIN_W-1:0]  pin_entry;
  logic              pin_upd_valid;
  logic [PIN_W-1:0]  pin_upd_value;
  logic              session_end;
  logic              auth_ok;
  logic              auth_fail;
  logic              card_locked;
  logic              card_eject;
  logic [2:0]        tries_left;
  logic [3:0]        acct_idx;

  modport master (
    output card_in, acct_no, pin_valid, pin_entry, pin_upd_valid, pin_upd_value, session_end,
    input  auth_ok, auth_fail, card_locked, card_eject, tries_left, acct_idx
  );

  modport slave (
    input  card_in, acct_no, pin_valid, pin_entry, pin_upd_valid, pin_upd_value, session_end,
    output auth_ok, auth_fail, card_locked, card_eject, tries_left, acct_idx
  );
endinterface

// File: rtl/atm_pin_table.sv
// Per-account PIN storage and permanent lock bits; synchronous write, combinational read.
module atm_pin_table
  import atm_pkg::*;
#(
  parameter int NUM_ACCTS = 4,
  parameter int PIN_W     = PIN_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [3:0]           i_wr_idx,
  input  logic [PIN_W-1:0]     i_wr_pin,
  input  logic                 i_lock_en,
  input  logic [3:0]           i_lock_idx,
  input  logic [3:0]           i_rd_idx,
  output logic [PIN_W-1:0]     o_rd_pin,
  output logic [NUM_ACCTS-1:0] o_locked
);
  logic [PIN_W-1:0]     r_pin [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] r_locked;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ACCTS; i++) begin
      if (!reset) begin
        r_pin[i]    <= PIN_W'(DEFAULT_PIN[i]);
        r_locked[i] <= 1'b0;
      end else begin
        if (i_wr_en && (i_wr_idx == 4'(i))) r_pin[i] <= i_wr_pin;
        if (i_lock_en && (i_lock_idx == 4'(i))) r_locked[i] <= 1'b1;
      end
    end
  end

  // Mux-based read keeps out-of-range indices harmless for non power-of-two tables.
  always_comb begin
    o_rd_pin = '0;
    for (int i = 0; i < NUM_ACCTS; i++) begin
      if (i_rd_idx == 4'(i)) o_rd_pin = r_pin[i];
    end
  end

  assign o_locked = r_locked;

endmodule

// File: rtl/atm_pin_auth.sv
// Card/PIN authentication stage: account lookup, PIN attempts with lockout and
// entry timeout, and the session grant (auth_ok) that gates the ATM transaction FSM.
module atm_pin_auth
  import atm_pkg::*;
#(
  parameter int NUM_ACCTS   = 4,
  parameter int ACCT_W      = ACCT_W_DEF,
  parameter int PIN_W       = PIN_W_DEF,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic           clk,
  input logic           reset,
  atm_pin_auth_if.slave auth_bus
);
  localparam int               TMR_W      = $clog2(TIMEOUT_CYC);
  localparam logic [2:0]       TRIES_INIT = 3'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);

  state_t               r_state, w_state_next;
  logic                 r_card_prev;
  logic [ACCT_W-1:0]    r_acct;
  logic [PIN_W-1:0]     r_pin_try;
  logic [3:0]           r_acct_idx, w_acct_idx_next;
  logic [2:0]           r_tries, w_tries_next, w_tries_dec;
  logic [TMR_W-1:0]     r_timer, w_timer_next;
  logic [NUM_ACCTS-1:0] w_match, w_locked;
  logic                 w_hit, w_hit_locked;
  logic [3:0]           w_hit_idx;
  logic [PIN_W-1:0]     w_stored_pin;
  logic                 w_pin_ok, w_card_rise, w_card_fall;
  logic                 w_lock_en, w_wr_en;

  assign w_card_rise = auth_bus.card_in & ~r_card_prev;
  assign w_card_fall = ~auth_bus.card_in & r_card_prev;
  assign w_pin_ok    = (r_pin_try == w_stored_pin);
  assign w_wr_en     = (r_state == ST_AUTH) && auth_bus.pin_upd_valid;
  assign w_tries_dec = (r_tries != 3'd0) ? (r_tries - 3'd1) : 3'd0;

  generate
    for (genvar gi = 0; gi < NUM_ACCTS; gi++) begin : g_match
      assign w_match[gi] = (r_acct == ACCT_W'(ACCT_NO[gi]));
    end
  endgenerate

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    w_hit        = 1'b0;
    w_hit_idx    = '0;
    w_hit_locked = 1'b0;
    for (int i = NUM_ACCTS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit        = 1'b1;
        w_hit_idx    = 4'(i);
        w_hit_locked = w_locked[i];
      end
    end
  end

  atm_pin_table #(.NUM_ACCTS(NUM_ACCTS), .PIN_W(PIN_W)) u_pin_table (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_acct_idx),
    .i_wr_pin   (auth_bus.pin_upd_value),
    .i_lock_en  (w_lock_en),
    .i_lock_idx (r_acct_idx),
    .i_rd_idx   (r_acct_idx),
    .o_rd_pin   (w_stored_pin),
    .o_locked   (w_locked)
  );

  always_comb begin
    w_state_next    = r_state;
    w_acct_idx_next = r_acct_idx;
    w_tries_next    = r_tries;
    w_timer_next    = r_timer;
    w_lock_en       = 1'b0;
    case (r_state)
      ST_IDLE: if (w_card_rise) w_state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        w_acct_idx_next = w_hit_idx;
        if (!w_hit) begin
          w_state_next = ST_EJECT;
        end else if (w_hit_locked) begin
          w_state_next = ST_LOCKED;
        end else begin
          w_tries_next = TRIES_INIT;
          w_timer_next = '0;
          w_state_next = ST_WAIT_PIN;
        end
      end
      ST_WAIT_PIN: begin
        if (auth_bus.pin_valid)       w_state_next = ST_CHECK;
        else if (r_timer == TMR_LAST) w_state_next = ST_EJECT;
        else                          w_timer_next = r_timer + 1'b1;
      end
      ST_CHECK: begin
        if (w_pin_ok) begin
          w_state_next = ST_AUTH;
        end else begin
          w_tries_next = w_tries_dec;
          if (w_tries_dec == 3'd0) begin
            w_lock_en    = 1'b1;
            w_state_next = ST_LOCKED;
          end else begin
            w_timer_next = '0;
            w_state_next = ST_WAIT_PIN;
          end
        end
      end
      ST_AUTH:   if (auth_bus.session_end) w_state_next = ST_EJECT;
      ST_LOCKED: w_state_next = ST_EJECT;
      ST_EJECT:  w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    // Pulling the card aborts silently; a lock earned on the last attempt still sticks.
    if (w_card_fall && (r_state != ST_IDLE) && (r_state != ST_EJECT)) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_card_prev <= 1'b0;
      r_acct      <= '0;
      r_pin_try   <= '0;
      r_acct_idx  <= '0;
      r_tries     <= TRIES_INIT;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_card_prev <= auth_bus.card_in;
      r_acct_idx  <= w_acct_idx_next;
      r_tries     <= w_tries_next;
      r_timer     <= w_timer_next;
      if ((r_state == ST_IDLE) && w_card_rise) r_acct <= auth_bus.acct_no;
      if ((r_state == ST_WAIT_PIN) && auth_bus.pin_valid) r_pin_try <= auth_bus.pin_entry;
    end
  end

  assign auth_bus.auth_ok     = (r_state == ST_AUTH);
  assign auth_bus.auth_fail   = (r_state == ST_CHECK) && !w_pin_ok;
  assign auth_bus.card_locked = (r_state == ST_LOCKED);
  assign auth_bus.card_eject  = (r_state == ST_EJECT);
  assign auth_bus.tries_left  = (r_state == ST_IDLE) ? 3'd0 : r_tries;
  assign auth_bus.acct_idx    = (r_state == ST_IDLE) ? 4'd0 : r_acct_idx;

endmodule

// File: tb/tb_atm_pin_auth.sv
// Scenario bench for atm_pin_auth: directed feature tasks plus randomized sessions
// checked against an account-level model (PINs, lock flags, per-session attempts).
module tb_atm_pin_auth;
  import atm_pkg::*;

  localparam int NA = 4;
  localparam int AW = 17;
  localparam int PW = 17;
  localparam int MT = 3;
  localparam int TO = 50;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  atm_pin_auth_if #(.ACCT_W(AW), .PIN_W(PW)) bus ();

  atm_pin_auth #(
    .NUM_ACCTS(NA), .ACCT_W(AW), .PIN_W(PW), .MAX_TRIES(MT), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .auth_bus(bus)
  );

  logic [PW-1:0] m_pin [NA];
  bit            m_locked [NA];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic void model_reset();
    for (int i = 0; i < NA; i++) begin
      m_pin[i]    = DEFAULT_PIN[i];
      m_locked[i] = 1'b0;
    end
  endfunction

  function automatic int lookup(input logic [AW-1:0] a);
    for (int i = 0; i < NA; i++) if (ACCT_NO[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [PW-1:0] wrong_pin(input int i);
    logic [PW-1:0] d;
    d = PW'($urandom_range(1, (1 << PW) - 1));
    return m_pin[i] ^ d;
  endfunction

  function automatic int pick_unlocked();
    int s;
    s = $urandom_range(0, NA - 1);
    for (int k = 0; k < NA; k++) if (!m_locked[(s + k) % NA]) return (s + k) % NA;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Leaves the DUT one edge after the lookup decision.
  task automatic insert(input logic [AW-1:0] acct);
    bus.card_in = 1'b0;
    tick();
    bus.card_in = 1'b1;
    bus.acct_no = acct;
    ticks(2);
  endtask

  // Leaves the DUT in the check cycle of the attempt.
  task automatic enter_pin(input logic [PW-1:0] p);
    bus.pin_valid = 1'b1;
    bus.pin_entry = p;
    tick();
    bus.pin_valid = 1'b0;
  endtask

  task automatic end_session();
    bus.session_end = 1'b1;
    tick();
    bus.session_end = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ticks(3);
    n_vec++; if (bus.auth_ok !== 1'b0) begin n_err++; $display("FAIL rst_auth_ok: got %b want 0", bus.auth_ok); end
    n_vec++; if (bus.auth_fail !== 1'b0) begin n_err++; $display("FAIL rst_auth_fail: got %b want 0", bus.auth_fail); end
    n_vec++; if (bus.card_locked !== 1'b0) begin n_err++; $display("FAIL rst_locked: got %b want 0", bus.card_locked); end
    n_vec++; if (bus.card_eject !== 1'b0) begin n_err++; $display("FAIL rst_eject: got %b want 0", bus.card_eject); end
    n_vec++; if (bus.tries_left !== 3'd0) begin n_err++; $display("FAIL rst_tries: got %0d want 0", bus.tries_left); end
    n_vec++; if (bus.acct_idx !== 4'd0) begin n_err++; $display("FAIL rst_idx: got %0d want 0", bus.acct_idx); end
    reset = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_auth();
    int a;
    for (int r = 0; r < 3; r++) begin
      a = (r == 0) ? 1 : $urandom_range(0, NA - 1);
      insert(ACCT_NO[a]);
      n_vec++; if (bus.tries_left !== 3'(MT)) begin n_err++; $display("FAIL auth_tries_wait: got %0d want %0d", bus.tries_left, MT); end
      n_vec++; if (bus.acct_idx !== 4'(a)) begin n_err++; $display("FAIL auth_idx: got %0d want %0d", bus.acct_idx, a); end
      enter_pin(m_pin[a]);
      n_vec++; if (bus.auth_ok !== 1'b0) begin n_err++; $display("FAIL auth_early: got %b want 0", bus.auth_ok); end
      n_vec++; if (bus.auth_fail !== 1'b0) begin n_err++; $display("FAIL auth_nofail: got %b want 0", bus.auth_fail); end
      tick();
      n_vec++; if (bus.auth_ok !== 1'b1) begin n_err++; $display("FAIL auth_ok: got %b want 1", bus.auth_ok); end
      n_vec++; if (bus.tries_left !== 3'(MT)) begin n_err++; $display("FAIL auth_tries: got %0d want %0d", bus.tries_left, MT); end
      end_session();
      n_vec++; if ({bus.card_eject, bus.auth_ok} !== 2'b10) begin n_err++; $display("FAIL auth_eject: got eject=%b ok=%b want 1/0", bus.card_eject, bus.auth_ok); end
      tick();
      n_vec++; if (bus.card_eject !== 1'b0) begin n_err++; $display("FAIL auth_eject_pulse: got %b want 0", bus.card_eject); end
      $display("auth session: acct %05h idx %0d granted", ACCT_NO[a], a);
    end
  endtask

  task automatic test_unknown();
    logic [AW-1:0] acct;
    bus.card_in = 1'b0;
    tick();
    bus.card_in = 1'b1;
    bus.acct_no = 17'h1FFFF;
    tick();
    n_vec++; if (bus.card_eject !== 1'b0) begin n_err++; $display("FAIL unk_eject_early: got %b want 0", bus.card_eject); end
    tick();
    n_vec++; if ({bus.card_eject, bus.auth_ok} !== 2'b10) begin n_err++; $display("FAIL unk_eject: got eject=%b ok=%b want 1/0", bus.card_eject, bus.auth_ok); end
    tick();
    n_vec++; if ({bus.card_eject, bus.auth_ok} !== 2'b00) begin n_err++; $display("FAIL unk_after: got eject=%b ok=%b want 0/0", bus.card_eject, bus.auth_ok); end
    acct = AW'($urandom);
    for (int k = 0; k < 8 && lookup(acct) >= 0; k++) acct = AW'($urandom);
    insert(acct);
    n_vec++; if (bus.card_eject !== 1'(lookup(acct) < 0)) begin n_err++; $display("FAIL unk_rand_eject: acct %05h got %b", acct, bus.card_eject); end
    tick();
    $display("unknown card: acct %05h ejected", acct);
  endtask

  task automatic test_lockout();
    int b;
    b = pick_unlocked();
    insert(ACCT_NO[b]);
    for (int t = 1; t <= MT; t++) begin
      enter_pin(wrong_pin(b));
      n_vec++; if (bus.auth_fail !== 1'b1) begin n_err++; $display("FAIL lock_fail_%0d: got %b want 1", t, bus.auth_fail); end
      tick();
      n_vec++; if (bus.auth_fail !== 1'b0) begin n_err++; $display("FAIL lock_fail_pulse_%0d: got %b want 0", t, bus.auth_fail); end
      if (t < MT) begin
        n_vec++; if (bus.tries_left !== 3'(MT - t)) begin n_err++; $display("FAIL lock_tries_%0d: got %0d want %0d", t, bus.tries_left, MT - t); end
      end else begin
        n_vec++; if (bus.card_locked !== 1'b1) begin n_err++; $display("FAIL lock_locked: got %b want 1", bus.card_locked); end
      end
    end
    tick();
    n_vec++; if ({bus.card_eject, bus.card_locked} !== 2'b10) begin n_err++; $display("FAIL lock_eject: got eject=%b locked=%b want 1/0", bus.card_eject, bus.card_locked); end
    m_locked[b] = 1'b1;
    tick();
    insert(ACCT_NO[b]);
    n_vec++; if (bus.card_locked !== 1'b1) begin n_err++; $display("FAIL relock: got %b want 1", bus.card_locked); end
    enter_pin(m_pin[b]);
    n_vec++; if ({bus.card_eject, bus.auth_ok} !== 2'b10) begin n_err++; $display("FAIL relock_eject: got eject=%b ok=%b want 1/0", bus.card_eject, bus.auth_ok); end
    tick();
    n_vec++; if (bus.auth_ok !== 1'b0) begin n_err++; $display("FAIL relock_noauth: got %b want 0", bus.auth_ok); end
    $display("lockout: acct idx %0d locked", b);
  endtask

  task automatic test_timeout();
    int a;
    a = pick_unlocked();
    insert(ACCT_NO[a]);
    ticks(TO - 1);
    n_vec++; if (bus.card_eject !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", bus.card_eject); end
    tick();
    n_vec++; if (bus.card_eject !== 1'b1) begin n_err++; $display("FAIL to_eject: got %b want 1", bus.card_eject); end
    tick();
    insert(ACCT_NO[a]);
    ticks(TO - 1);
    enter_pin(m_pin[a]);
    n_vec++; if ({bus.card_eject, bus.auth_fail} !== 2'b00) begin n_err++; $display("FAIL to_edge_pin: got eject=%b fail=%b want 0/0", bus.card_eject, bus.auth_fail); end
    tick();
    n_vec++; if (bus.auth_ok !== 1'b1) begin n_err++; $display("FAIL to_edge_auth: got %b want 1", bus.auth_ok); end
    end_session();
    tick();
    $display("timeout: idx %0d ejected, then accepted on timeout cycle", a);
  endtask

  task automatic test_pin_change();
    int c;
    logic [PW-1:0] old_pin;
    c = pick_unlocked();
    old_pin = m_pin[c];
    insert(ACCT_NO[c]);
    bus.pin_upd_valid = 1'b1;
    bus.pin_upd_value = 17'h0BEEF;
    tick();
    bus.pin_upd_valid = 1'b0;
    enter_pin(m_pin[c]);
    tick();
    n_vec++; if (bus.auth_ok !== 1'b1) begin n_err++; $display("FAIL chg_auth: got %b want 1", bus.auth_ok); end
    bus.pin_valid = 1'b1;
    bus.pin_entry = wrong_pin(c);
    tick();
    bus.pin_valid = 1'b0;
    n_vec++; if ({bus.auth_ok, bus.auth_fail} !== 2'b10) begin n_err++; $display("FAIL chg_pin_ignored: got ok=%b fail=%b want 1/0", bus.auth_ok, bus.auth_fail); end
    bus.pin_upd_valid = 1'b1;
    bus.pin_upd_value = 17'h1234;
    tick();
    bus.pin_upd_valid = 1'b0;
    m_pin[c] = 17'h1234;
    end_session();
    tick();
    insert(ACCT_NO[c]);
    enter_pin(old_pin);
    n_vec++; if (bus.auth_fail !== 1'b1) begin n_err++; $display("FAIL chg_old_pin: got %b want 1", bus.auth_fail); end
    tick();
    enter_pin(m_pin[c]);
    n_vec++; if (bus.auth_fail !== 1'b0) begin n_err++; $display("FAIL chg_new_pin: got %b want 0", bus.auth_fail); end
    tick();
    n_vec++; if (bus.auth_ok !== 1'b1) begin n_err++; $display("FAIL chg_new_auth: got %b want 1", bus.auth_ok); end
    end_session();
    tick();
    $display("pin change: idx %0d now %05h", c, m_pin[c]);
  endtask

  task automatic test_card_drop();
    int a;
    a = pick_unlocked();
    insert(ACCT_NO[a]);
    bus.card_in = 1'b0;
    tick();
    n_vec++; if ({bus.card_eject, bus.tries_left} !== 4'b0000) begin n_err++; $display("FAIL drop_wait: got eject=%b tries=%0d want 0/0", bus.card_eject, bus.tries_left); end
    tick();
    n_vec++; if (bus.card_eject !== 1'b0) begin n_err++; $display("FAIL drop_wait_noeject: got %b want 0", bus.card_eject); end
    insert(ACCT_NO[a]);
    enter_pin(m_pin[a]);
    tick();
    bus.card_in = 1'b0;
    tick();
    n_vec++; if ({bus.auth_ok, bus.card_eject} !== 2'b00) begin n_err++; $display("FAIL drop_auth: got ok=%b eject=%b want 0/0", bus.auth_ok, bus.card_eject); end
    tick();
    n_vec++; if (bus.card_eject !== 1'b0) begin n_err++; $display("FAIL drop_auth_noeject: got %b want 0", bus.card_eject); end
    $display("card drop: idx %0d aborted twice without eject", a);
  endtask

  task automatic test_reset_mid();
    int a;
    a = pick_unlocked();
    insert(ACCT_NO[a]);
    enter_pin(m_pin[a]);
    tick();
    reset = 1'b0;
    tick();
    n_vec++; if ({bus.auth_ok, bus.auth_fail, bus.card_locked, bus.card_eject} !== 4'b0000) begin n_err++; $display("FAIL rstmid_flags: got %b%b%b%b want 0000", bus.auth_ok, bus.auth_fail, bus.card_locked, bus.card_eject); end
    n_vec++; if ({bus.tries_left, bus.acct_idx} !== 7'd0) begin n_err++; $display("FAIL rstmid_fields: got tries=%0d idx=%0d want 0/0", bus.tries_left, bus.acct_idx); end
    bus.card_in = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < NA; i++) begin
      insert(ACCT_NO[i]);
      enter_pin(m_pin[i]);
      tick();
      n_vec++; if (bus.auth_ok !== 1'b1) begin n_err++; $display("FAIL rstmid_default_%0d: got %b want 1", i, bus.auth_ok); end
      bus.card_in = 1'b0;
      tick();
    end
    $display("mid-session reset: defaults and locks restored");
  endtask

  task automatic test_random();
    int k, tries;
    bit good, done;
    logic [AW-1:0] acct;
    string outcome;
    for (int s = 0; s < 40; s++) begin
      k = $urandom_range(0, NA);
      acct = (k == NA) ? 17'h1FFFF : ACCT_NO[k];
      if (k == NA && $urandom_range(0, 1) == 1) acct = AW'($urandom) | 17'h10000;
      insert(acct);
      if (k == NA) begin
        outcome = "unknown";
        n_vec++; if (bus.card_eject !== 1'b1) begin n_err++; $display("FAIL rnd_unknown_%0d: got %b want 1", s, bus.card_eject); end
        tick();
      end else if (m_locked[k]) begin
        outcome = "locked";
        n_vec++; if (bus.card_locked !== 1'b1) begin n_err++; $display("FAIL rnd_locked_%0d: got %b want 1", s, bus.card_locked); end
        ticks(2);
      end else begin
        tries = MT;
        done  = 1'b0;
        outcome = "";
        n_vec++; if (bus.tries_left !== 3'(tries)) begin n_err++; $display("FAIL rnd_tries0_%0d: got %0d want %0d", s, bus.tries_left, tries); end
        while (!done) begin
          good = ($urandom_range(0, 2) != 0);
          enter_pin(good ? m_pin[k] : wrong_pin(k));
          n_vec++; if (bus.auth_fail !== !good) begin n_err++; $display("FAIL rnd_fail_%0d: got %b want %b", s, bus.auth_fail, !good); end
          tick();
          if (good) begin
            n_vec++; if (bus.auth_ok !== 1'b1) begin n_err++; $display("FAIL rnd_auth_%0d: got %b want 1", s, bus.auth_ok); end
            if ($urandom_range(0, 1) == 1) begin
              bus.pin_upd_valid = 1'b1;
              bus.pin_upd_value = PW'($urandom);
              m_pin[k] = bus.pin_upd_value;
              tick();
              bus.pin_upd_valid = 1'b0;
            end
            end_session();
            n_vec++; if (bus.card_eject !== 1'b1) begin n_err++; $display("FAIL rnd_eject_%0d: got %b want 1", s, bus.card_eject); end
            tick();
            outcome = "granted";
            done = 1'b1;
          end else begin
            tries--;
            if (tries == 0) begin
              m_locked[k] = 1'b1;
              n_vec++; if (bus.card_locked !== 1'b1) begin n_err++; $display("FAIL rnd_lock_%0d: got %b want 1", s, bus.card_locked); end
              ticks(2);
              outcome = "now locked";
              done = 1'b1;
            end else begin
              n_vec++; if (bus.tries_left !== 3'(tries)) begin n_err++; $display("FAIL rnd_tries_%0d: got %0d want %0d", s, bus.tries_left, tries); end
            end
          end
        end
      end
      $display("random session %0d: acct %05h -> %s", s, acct, outcome);
    end
  endtask

  initial begin
    bus.card_in       = 1'b0;
    bus.acct_no       = '0;
    bus.pin_valid     = 1'b0;
    bus.pin_entry     = '0;
    bus.pin_upd_valid = 1'b0;
    bus.pin_upd_value = '0;
    bus.session_end   = 1'b0;
    test_reset();
    test_auth();
    test_unknown();
    test_lockout();
    test_timeout();
    test_pin_change();
    test_card_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule
